// File: rtl/pong_pkg.sv
// Shared types for the Pong match sequencer: state encodings,
// default winning score and the serve/winner side encodings.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SERVE  = 3'd1,
        ST_RALLY  = 3'd2,
        ST_POINT  = 3'd3,
        ST_CHECK  = 3'd4,
        ST_PAUSED = 3'd5,
        ST_OVER   = 3'd6
    } match_state_e;

    localparam int WIN_TEN_DEF = 1;
    localparam int WIN_ONE_DEF = 1;

    localparam logic DIR_PLAYER   = 1'b0;
    localparam logic DIR_COMPUTER = 1'b1;

    localparam logic WIN_PLAYER   = 1'b0;
    localparam logic WIN_COMPUTER = 1'b1;

    // True once a two-digit BCD score has reached the target score.
    function automatic logic score_reached(
        input logic [3:0] ten,
        input logic [3:0] one,
        input logic [3:0] win_ten,
        input logic [3:0] win_one
    );
        return (ten > win_ten) || ((ten == win_ten) && (one >= win_one));
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector on an already synchronized level; the
// previous value is registered so the edge is seen for one cycle.
module rise_detect (
    input  logic clk,
    input  logic Reset,
    input  logic d,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= d;
        end
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer for Pong: serve delay, rally, point strobes to the
// BCD score counter, win check and game-over hold.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int SERVE_DELAY = 60,
    parameter int WIN_TEN     = WIN_TEN_DEF,
    parameter int WIN_ONE     = WIN_ONE_DEF,
    parameter int DLY_W       = 8
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       start,
    input  logic       pause,
    input  logic       miss_left,
    input  logic       miss_right,
    input  logic [3:0] p_ten,
    input  logic [3:0] p_one,
    input  logic [3:0] c_ten,
    input  logic [3:0] c_one,
    output logic       PScore,
    output logic       CScore,
    output logic       score_clr,
    output logic       ball_rst,
    output logic       ball_en,
    output logic       serve_dir,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state_dbg
);

    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(SERVE_DELAY - 1);
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
    localparam logic [3:0]       WT       = 4'(WIN_TEN);
    localparam logic [3:0]       WO       = 4'(WIN_ONE);

    logic start_rise;
    logic miss_l_rise;
    logic miss_r_rise;

    rise_detect u_start_rd (
        .clk   (clk),
        .Reset (Reset),
        .d     (start),
        .rise  (start_rise)
    );

    rise_detect u_miss_l_rd (
        .clk   (clk),
        .Reset (Reset),
        .d     (miss_left),
        .rise  (miss_l_rise)
    );

    rise_detect u_miss_r_rd (
        .clk   (clk),
        .Reset (Reset),
        .d     (miss_right),
        .rise  (miss_r_rise)
    );

    match_state_e     state_q, state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             pscore_q, pscore_d;
    logic             cscore_q, cscore_d;
    logic             clr_q, clr_d;
    logic             dir_q, dir_d;
    logic             win_q, win_d;

    logic p_won;
    logic c_won;

    assign p_won = score_reached(p_ten, p_one, WT, WO);
    assign c_won = score_reached(c_ten, c_one, WT, WO);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            dly_q    <= '0;
            pscore_q <= 1'b0;
            cscore_q <= 1'b0;
            clr_q    <= 1'b0;
            dir_q    <= DIR_COMPUTER;
            win_q    <= WIN_PLAYER;
        end else begin
            state_q  <= state_d;
            dly_q    <= dly_d;
            pscore_q <= pscore_d;
            cscore_q <= cscore_d;
            clr_q    <= clr_d;
            dir_q    <= dir_d;
            win_q    <= win_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dly_d    = dly_q;
        pscore_d = 1'b0;
        cscore_d = 1'b0;
        clr_d    = 1'b0;
        dir_d    = dir_q;
        win_d    = win_q;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_SERVE;
                    dir_d   = DIR_COMPUTER;
                    dly_d   = DLY_LOAD;
                end
            end
            ST_SERVE: begin
                if (dly_q == '0) begin
                    state_d = ST_RALLY;
                end else begin
                    dly_d = dly_q - DLY_ONE;
                end
            end
            ST_RALLY: begin
                // A simultaneous double miss credits the player only.
                if (pause) begin
                    state_d = ST_PAUSED;
                end else if (miss_r_rise) begin
                    pscore_d = 1'b1;
                    dir_d    = DIR_COMPUTER;
                    state_d  = ST_POINT;
                end else if (miss_l_rise) begin
                    cscore_d = 1'b1;
                    dir_d    = DIR_PLAYER;
                    state_d  = ST_POINT;
                end
            end
            ST_PAUSED: begin
                if (!pause) begin
                    state_d = ST_RALLY;
                end
            end
            ST_POINT: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (p_won) begin
                    win_d   = WIN_PLAYER;
                    state_d = ST_OVER;
                end else if (c_won) begin
                    win_d   = WIN_COMPUTER;
                    state_d = ST_OVER;
                end else begin
                    dly_d   = DLY_LOAD;
                    state_d = ST_SERVE;
                end
            end
            ST_OVER: begin
                if (start_rise) begin
                    clr_d   = 1'b1;
                    win_d   = WIN_PLAYER;
                    dir_d   = DIR_COMPUTER;
                    dly_d   = DLY_LOAD;
                    state_d = ST_SERVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ball_rst  = 1'b1;
        ball_en   = 1'b0;
        game_over = 1'b0;
        case (state_q)
            ST_RALLY: begin
                ball_rst = 1'b0;
                ball_en  = 1'b1;
            end
            ST_PAUSED, ST_POINT, ST_CHECK: begin
                ball_rst = 1'b0;
            end
            ST_OVER: begin
                game_over = 1'b1;
            end
            default: begin
                ball_rst = 1'b1;
            end
        endcase
    end

    assign PScore    = pscore_q;
    assign CScore    = cscore_q;
    assign score_clr = clr_q;
    assign serve_dir = dir_q;
    assign winner    = win_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Randomized bench for pong_match_ctrl against a score-level
// reference model that also plays the role of the BCD counter.
module tb_pong_match_ctrl;

    localparam int SD     = 4;
    localparam int WT     = 1;
    localparam int WO     = 1;
    localparam int TARGET = WT * 10 + WO;

    localparam int IDLE   = 0;
    localparam int SERVE  = 1;
    localparam int RALLY  = 2;
    localparam int POINT  = 3;
    localparam int CHECK  = 4;
    localparam int PAUSED = 5;
    localparam int OVER   = 6;

    logic       clk = 1'b0;
    logic       Reset;
    logic       start, pause, miss_left, miss_right;
    logic [3:0] p_ten, p_one, c_ten, c_one;
    logic       PScore, CScore, score_clr, ball_rst, ball_en;
    logic       serve_dir, game_over, winner;
    logic [2:0] state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pong_match_ctrl #(
        .SERVE_DELAY (SD),
        .WIN_TEN     (WT),
        .WIN_ONE     (WO),
        .DLY_W       (8)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .start      (start),
        .pause      (pause),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .p_ten      (p_ten),
        .p_one      (p_one),
        .c_ten      (c_ten),
        .c_one      (c_one),
        .PScore     (PScore),
        .CScore     (CScore),
        .score_clr  (score_clr),
        .ball_rst   (ball_rst),
        .ball_en    (ball_en),
        .serve_dir  (serve_dir),
        .game_over  (game_over),
        .winner     (winner),
        .state_dbg  (state_dbg)
    );

    // Reference model: phase, strobes, and serve cycles still to wait.
    int m_st;
    bit m_p, m_c, m_clr, m_dir, m_win;
    int m_wait;
    bit pv_s, pv_l, pv_r;
    int ps, cs;
    bit hit_point_reset = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st   = IDLE;
        m_p    = 1'b0;
        m_c    = 1'b0;
        m_clr  = 1'b0;
        m_dir  = 1'b1;
        m_win  = 1'b0;
        m_wait = 0;
        pv_s   = 1'b0;
        pv_l   = 1'b0;
        pv_r   = 1'b0;
    endtask

    task automatic drive_digits();
        p_ten = 4'(ps / 10);
        p_one = 4'(ps % 10);
        c_ten = 4'(cs / 10);
        c_one = 4'(cs % 10);
    endtask

    task automatic compare_all();
        bit held;
        held = (m_st == IDLE) || (m_st == SERVE) || (m_st == OVER);
        check("state", state_dbg, m_st);
        check("ball_rst", ball_rst, held);
        check("ball_en", ball_en, m_st == RALLY);
        check("game_over", game_over, m_st == OVER);
        check("PScore", PScore, m_p);
        check("CScore", CScore, m_c);
        check("score_clr", score_clr, m_clr);
        check("serve_dir", serve_dir, m_dir);
        check("winner", winner, m_win);
    endtask

    // Advance the model across one rising edge using the driven inputs.
    task automatic model_step();
        bit rs, rl, rr;
        rs = start & ~pv_s;
        rl = miss_left & ~pv_l;
        rr = miss_right & ~pv_r;
        pv_s = start;
        pv_l = miss_left;
        pv_r = miss_right;

        if (m_p) ps++;
        if (m_c) cs++;
        if (m_clr) begin
            ps = 0;
            cs = 0;
        end

        m_p   = 1'b0;
        m_c   = 1'b0;
        m_clr = 1'b0;

        case (m_st)
            IDLE: if (rs) begin
                m_st = SERVE; m_dir = 1'b1; m_wait = SD;
            end
            SERVE: begin
                m_wait--;
                if (m_wait == 0) m_st = RALLY;
            end
            RALLY: begin
                if (pause) m_st = PAUSED;
                else if (rr) begin
                    m_p = 1'b1; m_dir = 1'b1; m_st = POINT;
                end else if (rl) begin
                    m_c = 1'b1; m_dir = 1'b0; m_st = POINT;
                end
            end
            PAUSED: if (!pause) m_st = RALLY;
            POINT: m_st = CHECK;
            CHECK: begin
                if (ps >= TARGET) begin
                    m_win = 1'b0; m_st = OVER;
                end else if (cs >= TARGET) begin
                    m_win = 1'b1; m_st = OVER;
                end else begin
                    m_st = SERVE; m_wait = SD;
                end
            end
            OVER: if (rs) begin
                m_clr = 1'b1; m_win = 1'b0; m_dir = 1'b1;
                m_st = SERVE; m_wait = SD;
            end
            default: m_st = IDLE;
        endcase
    endtask

    initial begin
        Reset      = 1'b1;
        start      = 1'b0;
        pause      = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;
        ps         = $urandom_range(0, TARGET - 1);
        cs         = $urandom_range(0, TARGET - 1);
        drive_digits();
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        Reset = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            start      = ($urandom_range(0, 3) == 0);
            miss_left  = ($urandom_range(0, 4) == 0);
            miss_right = ($urandom_range(0, 4) == 0);
            if (pause) pause = ($urandom_range(0, 3) != 0);
            else       pause = ($urandom_range(0, 19) == 0);
            model_step();
            drive_digits();
            @(negedge clk);
            compare_all();

            if ((m_st == POINT && !hit_point_reset) ||
                $urandom_range(0, 399) == 0) begin
                if (m_st == POINT) hit_point_reset = 1'b1;
                #2 Reset = 1'b1;
                #1;
                model_reset();
                ps = $urandom_range(0, TARGET - 1);
                cs = $urandom_range(0, TARGET - 1);
                drive_digits();
                compare_all();
                @(negedge clk);
                compare_all();
                Reset = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
